// File: rtl/dc_pkg.sv
// rtl/dc_pkg.sv - shared defaults, flush FSM states and tag-entry metadata for the dcache tag array
// Optional parity field enabled by DC_TAG_PARITY_EN.
package dc_pkg;

  localparam int DC_NUM_WAYS = 2;
  localparam int DC_NUM_SETS = 16;
  localparam int DC_TAG_W    = 12;

  typedef enum logic [1:0] {
    FL_IDLE  = 2'd0,
    FL_FLUSH = 2'd1,
    FL_DONE  = 2'd2
  } fl_state_e;

  // Tags live in a separate unreset array; this is the per-entry state that resets.
  typedef struct packed {
    logic valid;
    logic dirty;
`ifdef DC_TAG_PARITY_EN
    logic par;
`endif
  } dc_meta_t;

endpackage

// File: rtl/dc_tag_victim_sel.sv
// rtl/dc_tag_victim_sel.sv - victim way pick: lowest invalid way, else round-robin pointer
module dc_tag_victim_sel #(
  parameter  int NUM_WAYS = 2,
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0] valid_vec,
  input  logic [WAY_W-1:0]    rr_ptr,
  output logic [WAY_W-1:0]    victim_way,
  output logic                victim_valid
);

  always_comb begin
    victim_way   = rr_ptr;
    victim_valid = &valid_vec;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_vec[w]) victim_way = WAY_W'(w);
    end
  end

endmodule

// File: rtl/dc_tag_array_nway.sv
// rtl/dc_tag_array_nway.sv - N-way tag/valid/dirty array with registered hit compare, rr replacement, flush
// Optional per-entry even parity and rsp_par_err output under DC_TAG_PARITY_EN.
module dc_tag_array_nway
  import dc_pkg::*;
#(
  parameter  int NUM_WAYS = DC_NUM_WAYS,
  parameter  int NUM_SETS = DC_NUM_SETS,
  parameter  int TAG_W    = DC_TAG_W,
  localparam int IDX_W    = $clog2(NUM_SETS),
  localparam int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_valid,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_ready,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  output logic             rsp_dirty,
  output logic [TAG_W-1:0] rsp_victim_tag,
  output logic             rsp_victim_valid,
`ifdef DC_TAG_PARITY_EN
  output logic             rsp_par_err,
`endif
  input  logic             wr_en,
  input  logic             wr_fill,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [WAY_W-1:0] wr_way,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  logic             wr_dirty,
  input  logic             flush_req,
  output logic             busy
);

  logic [TAG_W-1:0] tag_q  [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0] tag_d  [NUM_SETS][NUM_WAYS];
  dc_meta_t         meta_q [NUM_SETS][NUM_WAYS];
  dc_meta_t         meta_d [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0] rr_q   [NUM_SETS];
  logic [WAY_W-1:0] rr_d   [NUM_SETS];
  fl_state_e        state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic             rsp_valid_q, rsp_valid_d, rsp_hit_q, rsp_hit_d;
  logic [WAY_W-1:0] rsp_way_q, rsp_way_d;
  logic             rsp_dirty_q, rsp_dirty_d, rsp_vv_q, rsp_vv_d;
  logic [TAG_W-1:0] rsp_vtag_q, rsp_vtag_d;
`ifdef DC_TAG_PARITY_EN
  logic                rsp_par_err_q, rsp_par_err_d;
  logic [NUM_WAYS-1:0] par_bad;
`endif

  logic                lk_fire, wr_ok, hit;
  logic [NUM_WAYS-1:0] set_valid, match_vec;
  logic [WAY_W-1:0]    hit_way, victim_way, sel_way;
  logic                victim_valid;

  assign busy     = (state_q != FL_IDLE);
  assign lk_ready = ~busy;
  assign lk_fire  = lk_valid & ~busy;
  assign wr_ok    = wr_en & ~busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      FL_IDLE: if (flush_req) begin
        state_d = FL_FLUSH;
        cnt_d   = '0;
      end
      FL_FLUSH: begin
        if (cnt_q == IDX_W'(NUM_SETS - 1)) state_d = FL_DONE;
        else                               cnt_d   = cnt_q + IDX_W'(1);
      end
      FL_DONE: state_d = FL_IDLE;
      default: state_d = FL_IDLE;
    endcase
  end

  always_comb begin
    tag_d  = tag_q;
    meta_d = meta_q;
    rr_d   = rr_q;
    if (wr_ok) begin
      tag_d[wr_index][wr_way]        = wr_tag;
      meta_d[wr_index][wr_way].valid = wr_valid;
      meta_d[wr_index][wr_way].dirty = wr_dirty;
`ifdef DC_TAG_PARITY_EN
      meta_d[wr_index][wr_way].par   = ^{wr_tag, wr_valid, wr_dirty};
`endif
      if (wr_fill) rr_d[wr_index] = rr_q[wr_index] + WAY_W'(1);
    end
    if (state_q == FL_FLUSH) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        meta_d[cnt_q][w] = '0;
`ifdef DC_TAG_PARITY_EN
        meta_d[cnt_q][w].par = ^tag_q[cnt_q][w];
`endif
      end
      rr_d[cnt_q] = '0;
    end
  end

  // Compare reads pre-write contents; a same-cycle write shows up next cycle.
  always_comb begin
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      set_valid[w] = meta_q[lk_index][w].valid;
`ifdef DC_TAG_PARITY_EN
      par_bad[w]   = (^{tag_q[lk_index][w], meta_q[lk_index][w].valid,
                        meta_q[lk_index][w].dirty}) != meta_q[lk_index][w].par;
      match_vec[w] = set_valid[w] & (tag_q[lk_index][w] == lk_tag) & ~par_bad[w];
`else
      match_vec[w] = set_valid[w] & (tag_q[lk_index][w] == lk_tag);
`endif
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (match_vec[w]) hit_way = WAY_W'(w);
    end
    hit     = |match_vec;
    sel_way = hit ? hit_way : victim_way;
  end

  dc_tag_victim_sel #(.NUM_WAYS(NUM_WAYS)) u_victim_sel (
    .valid_vec    (set_valid),
    .rr_ptr       (rr_q[lk_index]),
    .victim_way   (victim_way),
    .victim_valid (victim_valid)
  );

  always_comb begin
    rsp_valid_d = lk_fire;
    rsp_hit_d   = rsp_hit_q;
    rsp_way_d   = rsp_way_q;
    rsp_dirty_d = rsp_dirty_q;
    rsp_vtag_d  = rsp_vtag_q;
    rsp_vv_d    = rsp_vv_q;
`ifdef DC_TAG_PARITY_EN
    rsp_par_err_d = rsp_par_err_q;
`endif
    if (lk_fire) begin
      rsp_hit_d   = hit;
      rsp_way_d   = sel_way;
      rsp_dirty_d = meta_q[lk_index][sel_way].dirty;
      rsp_vtag_d  = tag_q[lk_index][victim_way];
      rsp_vv_d    = victim_valid;
`ifdef DC_TAG_PARITY_EN
      rsp_par_err_d = |par_bad;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) meta_q[s][w] <= '0;
        rr_q[s] <= '0;
      end
      state_q     <= FL_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_way_q   <= '0;
      rsp_dirty_q <= 1'b0;
      rsp_vtag_q  <= '0;
      rsp_vv_q    <= 1'b0;
`ifdef DC_TAG_PARITY_EN
      rsp_par_err_q <= 1'b0;
`endif
    end else begin
      meta_q      <= meta_d;
      rr_q        <= rr_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_way_q   <= rsp_way_d;
      rsp_dirty_q <= rsp_dirty_d;
      rsp_vtag_q  <= rsp_vtag_d;
      rsp_vv_q    <= rsp_vv_d;
`ifdef DC_TAG_PARITY_EN
      rsp_par_err_q <= rsp_par_err_d;
`endif
    end
  end

`ifdef DC_TAG_PARITY_EN
  // Tags reset to zero here so the cleared parity bit is consistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) tag_q[s][w] <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end
  assign rsp_par_err = rsp_par_err_q;
`else
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end
`endif

  assign rsp_valid        = rsp_valid_q;
  assign rsp_hit          = rsp_hit_q;
  assign rsp_way          = rsp_way_q;
  assign rsp_dirty        = rsp_dirty_q;
  assign rsp_victim_tag   = rsp_vtag_q;
  assign rsp_victim_valid = rsp_vv_q;

  a_single_hit: assert property (@(posedge clk) disable iff (!rst_n)
    lk_fire |-> $onehot0(match_vec));

endmodule

// File: tb/tb_dc_tag_array_nway.sv
// tb/tb_dc_tag_array_nway.sv - directed bench with a set-associative reference model and per-cycle compare
module tb_dc_tag_array_nway;

  localparam int NW = 2;
  localparam int NS = 16;
  localparam int TW = 12;
  localparam int IW = 4;
  localparam int WW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lk_valid = 1'b0;
  logic [IW-1:0] lk_index = '0;
  logic [TW-1:0] lk_tag = '0;
  logic          lk_ready;
  logic          rsp_valid, rsp_hit, rsp_dirty, rsp_victim_valid;
  logic [WW-1:0] rsp_way;
  logic [TW-1:0] rsp_victim_tag;
  logic          wr_en = 1'b0, wr_fill = 1'b0, wr_valid = 1'b0, wr_dirty = 1'b0;
  logic [IW-1:0] wr_index = '0;
  logic [WW-1:0] wr_way = '0;
  logic [TW-1:0] wr_tag = '0;
  logic          flush_req = 1'b0;
  logic          busy;
`ifdef DC_TAG_PARITY_EN
  logic          rsp_par_err;
`endif

  dc_tag_array_nway dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lk_valid         (lk_valid),
    .lk_index         (lk_index),
    .lk_tag           (lk_tag),
    .lk_ready         (lk_ready),
    .rsp_valid        (rsp_valid),
    .rsp_hit          (rsp_hit),
    .rsp_way          (rsp_way),
    .rsp_dirty        (rsp_dirty),
    .rsp_victim_tag   (rsp_victim_tag),
    .rsp_victim_valid (rsp_victim_valid),
`ifdef DC_TAG_PARITY_EN
    .rsp_par_err      (rsp_par_err),
`endif
    .wr_en            (wr_en),
    .wr_fill          (wr_fill),
    .wr_index         (wr_index),
    .wr_way           (wr_way),
    .wr_tag           (wr_tag),
    .wr_valid         (wr_valid),
    .wr_dirty         (wr_dirty),
    .flush_req        (flush_req),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sets of ways, a busy countdown for flush, and the expected response.
  int m_tag [NS][NW];
  bit m_val [NS][NW];
  bit m_dty [NS][NW];
  int m_rr  [NS];
  int busy_left;
  bit e_valid, e_hit, e_dirty, e_vv;
  int e_way, e_vtag;
  int mi, mv, ms;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NS; s++) begin
        for (int w = 0; w < NW; w++) begin m_val[s][w] = 0; m_dty[s][w] = 0; end
        m_rr[s] = 0;
      end
      busy_left = 0;
      e_valid = 0; e_hit = 0; e_dirty = 0; e_vv = 0; e_way = 0; e_vtag = 0;
    end else begin
      e_valid = 0;
      if (lk_valid && busy_left == 0) begin
        mi = int'(lk_index);
        e_valid = 1;
        e_hit = 0;
        e_way = 0;
        for (int w = 0; w < NW; w++)
          if (!e_hit && m_val[mi][w] && m_tag[mi][w] == int'(lk_tag)) begin
            e_hit = 1; e_way = w;
          end
        mv = -1;
        for (int w = 0; w < NW; w++) if (mv < 0 && !m_val[mi][w]) mv = w;
        e_vv = (mv < 0);
        if (mv < 0) mv = m_rr[mi];
        if (!e_hit) e_way = mv;
        e_dirty = m_dty[mi][e_way];
        e_vtag  = m_tag[mi][mv];
      end
      if (wr_en && busy_left == 0) begin
        m_tag[wr_index][wr_way] = int'(wr_tag);
        m_val[wr_index][wr_way] = wr_valid;
        m_dty[wr_index][wr_way] = wr_dirty;
        if (wr_fill) m_rr[wr_index] = (m_rr[wr_index] + 1) % NW;
      end
      if (busy_left > 0) begin
        ms = NS + 1 - busy_left;
        if (ms < NS) begin
          for (int w = 0; w < NW; w++) begin m_val[ms][w] = 0; m_dty[ms][w] = 0; end
          m_rr[ms] = 0;
        end
        busy_left--;
      end else if (flush_req) begin
        busy_left = NS + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", int'(busy), int'(busy_left > 0));
      chk("lk_ready", int'(lk_ready), int'(busy_left == 0));
      chk("rsp_valid", int'(rsp_valid), int'(e_valid));
      if (e_valid) begin
        chk("rsp_hit", int'(rsp_hit), int'(e_hit));
        chk("rsp_way", int'(rsp_way), e_way);
        chk("rsp_dirty", int'(rsp_dirty), int'(e_dirty));
        chk("rsp_victim_valid", int'(rsp_victim_valid), int'(e_vv));
        if (e_vv) chk("rsp_victim_tag", int'(rsp_victim_tag), e_vtag);
`ifdef DC_TAG_PARITY_EN
        chk("rsp_par_err", int'(rsp_par_err), 0);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input int i, input int t);
    lk_valid = 1'b1; lk_index = IW'(i); lk_tag = TW'(t);
    step();
    lk_valid = 1'b0;
  endtask

  task automatic write(input int i, input int w, input int t, input bit v, input bit d, input bit f);
    wr_en = 1'b1; wr_index = IW'(i); wr_way = WW'(w); wr_tag = TW'(t);
    wr_valid = v; wr_dirty = d; wr_fill = f;
    step();
    wr_en = 1'b0; wr_fill = 1'b0;
  endtask

  int n;

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_lk_ready", int'(lk_ready), 1);
    chk("reset_rsp_way", int'(rsp_way), 0);
    step();

    lookup(3, 'h0AB);
    chk("cold_valid", int'(rsp_valid), 1);
    chk("cold_hit", int'(rsp_hit), 0);
    chk("cold_way", int'(rsp_way), 0);
    chk("cold_vv", int'(rsp_victim_valid), 0);

    write(3, 1, 'h0AB, 1, 0, 1);
    lookup(3, 'h0AB);
    chk("fill_hit", int'(rsp_hit), 1);
    chk("fill_way", int'(rsp_way), 1);
    chk("fill_dirty", int'(rsp_dirty), 0);
    write(3, 1, 'h0AB, 1, 1, 0);
    lookup(3, 'h0AB);
    chk("dirty_set", int'(rsp_dirty), 1);

    write(5, 0, 'h111, 1, 0, 1);
    write(5, 1, 'h222, 1, 0, 1);
    lookup(5, 'h123);
    chk("rr_victim_way0", int'(rsp_way), 0);
    chk("rr_victim_valid", int'(rsp_victim_valid), 1);
    chk("rr_victim_tag0", int'(rsp_victim_tag), 'h111);
    write(5, 0, 'h123, 1, 0, 1);
    lookup(5, 'h456);
    chk("rr_victim_way1", int'(rsp_way), 1);
    chk("rr_victim_tag1", int'(rsp_victim_tag), 'h222);

    wr_en = 1'b1; wr_fill = 1'b1; wr_index = 7; wr_way = 0; wr_tag = 'h055;
    wr_valid = 1'b1; wr_dirty = 1'b0;
    lookup(7, 'h055);
    wr_en = 1'b0; wr_fill = 1'b0;
    chk("same_cycle_miss", int'(rsp_hit), 0);
    lookup(7, 'h055);
    chk("next_cycle_hit", int'(rsp_hit), 1);
    step();

    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      flush_req = (n == 5);
      lk_valid = (n == 8); lk_index = 3; lk_tag = 'h0AB;
      wr_en = (n == 15); wr_fill = 1'b1; wr_index = 0; wr_way = 0;
      wr_tag = 'h0AB; wr_valid = 1'b1; wr_dirty = 1'b0;
      step();
    end
    lk_valid = 1'b0; wr_en = 1'b0; wr_fill = 1'b0; flush_req = 1'b0;
    chk("flush_busy_cycles", n, 17);
    step();
    lookup(3, 'h0AB);
    chk("post_flush_miss3", int'(rsp_hit), 0);
    lookup(0, 'h0AB);
    chk("dropped_write_miss0", int'(rsp_hit), 0);
    for (int s = 0; s < NS; s++) lookup(s, 'h123);

    write(2, 0, 'h0C3, 1, 0, 1);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("reset_mid_flush_busy", int'(busy), 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    lookup(2, 'h0C3);
    chk("post_reset_miss", int'(rsp_hit), 0);
    chk("post_reset_vv", int'(rsp_victim_valid), 0);
    for (int s = 0; s < NS; s++) lookup(s, 'h0C3);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
